// File: rtl/pwm_generator.sv
// -----------------------------------------------------------------------------
// pwm_generator
//
// Fixed-frequency, 8-bit-resolution PWM generator with complementary outputs.
// The PWM period is PERIOD = CLK_FREQ / FREQUENCY system clocks. The duty
// threshold is captured on the first enabled cycle and on every period wrap,
// so mid-period duty changes never produce glitches.
//
// Optional feature macro: PWM_DEADTIME_EN
//   defined   : rising edges of out / nOut are each delayed by DEAD_CYCLES
//               clocks; falling edges are immediate; pulses no longer than
//               DEAD_CYCLES are suppressed.
//   undefined : nOut is the plain complement of out while running and
//               DEAD_CYCLES has no effect.
//
// Parameters
//   CLK_FREQ    : system clock frequency in Hz
//   FREQUENCY   : PWM frequency in Hz (2 <= PERIOD <= 65536)
//   DEAD_CYCLES : dead-time in clocks, 1..PERIOD/4 (dead-time build only)
//
// Ports
//   clk       in   system clock, all logic on the rising edge
//   rst       in   synchronous active-high reset (priority over enable)
//   enable    in   run PWM when high, outputs forced low when low
//   dutyCycle in   duty in 1/256 units
//   out       out  registered PWM output
//   nOut      out  registered complementary output
// -----------------------------------------------------------------------------
module pwm_generator #(
   parameter int CLK_FREQ    = 12_000_000,
   parameter int FREQUENCY   = 1_000_000,
   parameter int DEAD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] dutyCycle,
   output logic       out,
   output logic       nOut
);

   localparam int PERIOD = CLK_FREQ / FREQUENCY;
   localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int PW     = 8 + CW;

   if ((PERIOD < 2) || (PERIOD > 65536)) begin : g_bad_period
      $error("pwm_generator: PERIOD = CLK_FREQ / FREQUENCY must be within 2..65536");
   end

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_thr;
   logic          r_run;     // a period is in progress (thr and cnt are valid)

   logic [PW-1:0] w_prod;
   logic [CW-1:0] w_thr_new;
   logic          w_wrap;
   logic          w_p;

   // Full-width product; the >> 8 is a plain bit slice. The result is always
   // below PERIOD, so it fits the counter width.
   assign w_prod    = {{CW{1'b0}}, dutyCycle} * PW'(PERIOD);
   assign w_thr_new = w_prod[PW-1:8];
   assign w_wrap    = (r_cnt == CW'(PERIOD - 1));
   assign w_p       = (r_cnt < r_thr);

   // Period counter and threshold capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_run <= 1'b0;
         r_cnt <= {CW{1'b0}};
         r_thr <= {CW{1'b0}};
      end else if (!enable) begin
         // Idle: counter parked at 0, threshold reloaded on next enable
         r_run <= 1'b0;
         r_cnt <= {CW{1'b0}};
      end else if (!r_run || w_wrap) begin
         // Start of a period: first enabled cycle or wrap from PERIOD-1
         r_run <= 1'b1;
         r_cnt <= {CW{1'b0}};
         r_thr <= w_thr_new;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

`ifdef PWM_DEADTIME_EN

   localparam int DW = $clog2(DEAD_CYCLES + 1);

   if ((DEAD_CYCLES < 1) || (DEAD_CYCLES > (PERIOD / 4))) begin : g_bad_dead
      $error("pwm_generator: DEAD_CYCLES must be within 1..PERIOD/4");
   end

   // Each counter measures how long p has been continuously in its state,
   // saturating at DEAD_CYCLES; an output may only be high once its
   // counter has saturated.
   logic [DW-1:0] r_on_cnt;
   logic [DW-1:0] r_off_cnt;
   logic          w_on_done;
   logic          w_off_done;

   assign w_on_done  = (r_on_cnt  == DW'(DEAD_CYCLES));
   assign w_off_done = (r_off_cnt == DW'(DEAD_CYCLES));

   // Dead-time counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_on_cnt  <= {DW{1'b0}};
         r_off_cnt <= {DW{1'b0}};
         out       <= 1'b0;
         nOut      <= 1'b0;
      end else if (enable && r_run) begin
         if (w_p) begin
            r_off_cnt <= {DW{1'b0}};
            r_on_cnt  <= w_on_done ? r_on_cnt : (r_on_cnt + DW'(1));
         end else begin
            r_on_cnt  <= {DW{1'b0}};
            r_off_cnt <= w_off_done ? r_off_cnt : (r_off_cnt + DW'(1));
         end
         // p cannot be high and low at once, so out and nOut never overlap
         out  <= w_p  & w_on_done;
         nOut <= ~w_p & w_off_done;
      end else begin
         r_on_cnt  <= {DW{1'b0}};
         r_off_cnt <= {DW{1'b0}};
         out       <= 1'b0;
         nOut      <= 1'b0;
      end
   end

`else

   // DEAD_CYCLES is kept for a uniform parameter list; it has no effect here.
   if (DEAD_CYCLES < 0) begin : g_dead_cycles_unused
   end

   // Registered complementary outputs, low while idle or before the first
   // period has been set up
   always_ff @(posedge clk) begin
      if (rst) begin
         out  <= 1'b0;
         nOut <= 1'b0;
      end else if (enable && r_run) begin
         out  <= w_p;
         nOut <= ~w_p;
      end else begin
         out  <= 1'b0;
         nOut <= 1'b0;
      end
   end

`endif

endmodule

// File: tb/tb_pwm_generator.sv
// -----------------------------------------------------------------------------
// tb_pwm_generator
//
// Self-checking bench for pwm_generator with PERIOD = 12. A timeline model
// (elapsed clocks since the period train started, captured duty per period,
// and a sliding window of p for dead-time) is compared with the DUT on every
// falling edge. Directed sequences add literal expectations for high-time
// counts per period, first-rise latency, reset and disable behaviour.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwm_generator;

   localparam int CLK_FREQ  = 12_000_000;
   localparam int FREQUENCY = 1_000_000;
   localparam int PERIOD    = 12;
   localparam int DEAD      = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [7:0] dutyCycle;
   logic       out;
   logic       nOut;

   int n_checks = 0;
   int n_errors = 0;

   pwm_generator #(
      .CLK_FREQ   (CLK_FREQ),
      .FREQUENCY  (FREQUENCY),
      .DEAD_CYCLES(DEAD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .dutyCycle(dutyCycle),
      .out      (out),
      .nOut     (nOut)
   );

   always #5 clk = ~clk;

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- timeline model ----------------
   int   m_since = -1;   // clocks since the period train started, -1 when idle
   int   m_thr   = 0;
   bit   m_hist[$];      // p values since start, most recent last
   logic exp_out  = 1'b0;
   logic exp_nout = 1'b0;
   bit   m_valid  = 1'b0;

   always @(posedge clk) begin
      int  phase;
      bit  pv;
      bit  all_hi;
      bit  all_lo;
      if (rst || !enable) begin
         m_since = -1;
         m_hist.delete();
         exp_out  = 1'b0;
         exp_nout = 1'b0;
      end else if (m_since < 0) begin
         m_since  = 0;
         m_thr    = (int'(dutyCycle) * PERIOD) / 256;
         exp_out  = 1'b0;
         exp_nout = 1'b0;
      end else begin
         m_since++;
         phase = (m_since - 1) % PERIOD;
         pv    = (phase < m_thr);
         if ((m_since % PERIOD) == 0) m_thr = (int'(dutyCycle) * PERIOD) / 256;
`ifdef PWM_DEADTIME_EN
         m_hist.push_back(pv);
         if (m_hist.size() > DEAD + 1) void'(m_hist.pop_front());
         all_hi = (m_hist.size() == DEAD + 1);
         all_lo = all_hi;
         foreach (m_hist[k]) begin
            if (!m_hist[k]) all_hi = 1'b0;
            if (m_hist[k])  all_lo = 1'b0;
         end
         exp_out  = all_hi;
         exp_nout = all_lo;
`else
         all_hi   = 1'b0;
         all_lo   = 1'b0;
         exp_out  = pv;
         exp_nout = !pv;
`endif
      end
      m_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check_bit("model_out", out, exp_out);
         check_bit("model_nOut", nOut, exp_nout);
         check_bit("no_overlap", out & nOut, 1'b0);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic count_window(input logic [7:0] new_duty, input int change_at,
                               output int hi, output int nhi, output logic first);
      hi = 0;
      nhi = 0;
      first = 1'b0;
      for (int i = 0; i < PERIOD; i++) begin
         @(negedge clk);
         if (i == 0) first = out;
         hi  += int'(out);
         nhi += int'(nOut);
         if (i == change_at) dutyCycle = new_duty;
      end
   endtask

   // Hand-computed per-period high counts for seven consecutive periods:
   // duty 50, 50 (change to 128 mid-period), 128, 128 (change to 0), 0,
   // 0 (change to 255), 255.
`ifdef PWM_DEADTIME_EN
   int   exp_hi  [7] = '{1, 1, 5, 5, 0, 0, 10};
   int   exp_nhi [7] = '{9, 9, 5, 5, 12, 12, 0};
   logic exp_first_w1 = 1'b0;
   logic exp_first_w7 = 1'b0;
   logic exp_restart  = 1'b0;
`else
   int   exp_hi  [7] = '{2, 2, 6, 6, 0, 0, 11};
   int   exp_nhi [7] = '{10, 10, 6, 6, 12, 12, 1};
   logic exp_first_w1 = 1'b1;
   logic exp_first_w7 = 1'b1;
   logic exp_restart  = 1'b1;
`endif
   logic [7:0] win_duty [7] = '{8'd0, 8'd128, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0};
   int         win_chg  [7] = '{-1, 4, -1, 4, -1, 4, -1};

   initial begin
      int   hi;
      int   nhi;
      logic first;

      rst       = 1'b1;
      enable    = 1'b1;
      dutyCycle = 8'd50;

      // Reset held with enable high: both outputs low
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_bit("reset_out", out, 1'b0);
         check_bit("reset_nOut", nOut, 1'b0);
      end
      rst = 1'b0;

      // First enabled edge: period is set up, outputs still low
      @(negedge clk);
      check_bit("start_out", out, 1'b0);
      check_bit("start_nOut", nOut, 1'b0);

      // Seven whole periods
      for (int w = 0; w < 7; w++) begin
         count_window(win_duty[w], win_chg[w], hi, nhi, first);
         check_int($sformatf("period%0d_out_high", w + 1), hi, exp_hi[w]);
         check_int($sformatf("period%0d_nOut_high", w + 1), nhi, exp_nhi[w]);
         if (w == 0) check_bit("first_rise", first, exp_first_w1);
         if (w == 6) check_bit("duty255_period_start", first, exp_first_w7);
      end

      // Reset for 6 clocks mid-period (phase 4 of the next period)
      repeat (5) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_bit("midrst_out", out, 1'b0);
         check_bit("midrst_nOut", nOut, 1'b0);
      end
      rst = 1'b0;
      @(negedge clk);
      check_bit("restart_first_out", out, 1'b0);
      check_bit("restart_first_nOut", nOut, 1'b0);
      @(negedge clk);
      check_bit("restart_rise_out", out, exp_restart);
      check_bit("restart_rise_nOut", nOut, 1'b0);

      // Drop enable while out is high
      repeat (3) @(negedge clk);
      check_bit("pre_disable_out", out, 1'b1);
      enable = 1'b0;
      @(negedge clk);
      check_bit("disable_out", out, 1'b0);
      check_bit("disable_nOut", nOut, 1'b0);
      repeat (3) @(negedge clk);
      check_bit("idle_out", out, 1'b0);
      check_bit("idle_nOut", nOut, 1'b0);

      // Re-enable with a new duty; the model checks every cycle
      dutyCycle = 8'd128;
      enable    = 1'b1;
      repeat (30) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "time limit");
   end

endmodule
